// File: rtl/trap_ctl.sv
// Trap dispatch controller: latches overflow trap requests, waits for the
// instruction boundary, presents the trap offset to microcode and clears the flags.
module trap_ctl (
    input  logic       eboxClk,
    input  logic       eboxReset,
    input  logic       SCD_TRAP_REQ1,
    input  logic       SCD_TRAP_REQ2,
    input  logic       SCD_USER,
    input  logic       CON_TRAP_EN,
    input  logic       CON_INST_DONE,
    input  logic       PI_REQ,
    input  logic       PF_ABORT,
    input  logic       CON_TRAP_TAKEN,
    output logic       TRAP_PEND,
    output logic       TRAP_CYCLE,
    output logic [0:8] TRAP_OFFSET,
    output logic       TRAP_UPT,
    output logic       TRAP_CLR_REQ,
    output logic [1:2] TRAP_CLR_SEL,
    output logic       TRAP_HANG
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARM      = 2'd1,
        S_DISPATCH = 2'd2,
        S_CLEAR    = 2'd3
    } state_t;

    state_t     r_state, w_next;
    logic [1:2] r_v, w_v_next;
    logic       r_m, w_m_next;
    logic [7:0] r_wd, w_wd_next;
    logic       r_hang, w_hang_next;
    logic [1:2] w_req;

    logic       w_pend, w_cycle, w_upt, w_clr_req;
    logic [0:8] w_offset;
    logic [1:2] w_clr_sel;

    assign w_req = {SCD_TRAP_REQ1, SCD_TRAP_REQ2};

    function automatic logic [0:8] f_offset(input logic [1:2] v);
        case (v)
            2'b10:   f_offset = 9'o421;
            2'b01:   f_offset = 9'o422;
            2'b11:   f_offset = 9'o423;
            default: f_offset = 9'o000;
        endcase
    endfunction

    // Outputs are registered from next-state values so TRAP_CYCLE rises on
    // the same edge that samples CON_INST_DONE.
    always_ff @(posedge eboxClk) begin
        if (eboxReset) begin
            r_state      <= S_IDLE;
            r_v          <= 2'b00;
            r_m          <= 1'b0;
            r_wd         <= 8'd0;
            r_hang       <= 1'b0;
            TRAP_PEND    <= 1'b0;
            TRAP_CYCLE   <= 1'b0;
            TRAP_OFFSET  <= 9'd0;
            TRAP_UPT     <= 1'b0;
            TRAP_CLR_REQ <= 1'b0;
            TRAP_CLR_SEL <= 2'b00;
            TRAP_HANG    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_v          <= w_v_next;
            r_m          <= w_m_next;
            r_wd         <= w_wd_next;
            r_hang       <= w_hang_next;
            TRAP_PEND    <= w_pend;
            TRAP_CYCLE   <= w_cycle;
            TRAP_OFFSET  <= w_offset;
            TRAP_UPT     <= w_upt;
            TRAP_CLR_REQ <= w_clr_req;
            TRAP_CLR_SEL <= w_clr_sel;
            TRAP_HANG    <= w_hang_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_v_next  = r_v;
        w_m_next  = r_m;
        w_wd_next = r_wd;
        case (r_state)
            S_IDLE: begin
                if (CON_TRAP_EN && (|w_req)) begin
                    w_next   = S_ARM;
                    w_v_next = w_req;
                    w_m_next = SCD_USER;
                end
            end
            S_ARM: begin
                if (CON_INST_DONE && !PI_REQ) begin
                    w_next    = S_DISPATCH;
                    w_wd_next = 8'd0;
                end else begin
                    w_v_next = r_v | w_req;
                    w_m_next = SCD_USER;
                end
            end
            S_DISPATCH: begin
                // A page fail outranks the acknowledge; the dispatch is retried from ARM.
                if (PF_ABORT)
                    w_next = S_ARM;
                else if (CON_TRAP_TAKEN)
                    w_next = S_CLEAR;
                else if (r_wd != 8'hFF)
                    w_wd_next = r_wd + 8'd1;
            end
            S_CLEAR: begin
                w_next   = S_IDLE;
                w_v_next = 2'b00;
                w_m_next = 1'b0;
            end
            default: w_next = S_IDLE;
        endcase
        w_hang_next = r_hang | (w_wd_next == 8'hFF);
    end

    always_comb begin
        w_pend    = (w_next == S_ARM);
        w_cycle   = (w_next == S_DISPATCH);
        w_clr_req = (w_next == S_CLEAR);
        w_offset  = w_cycle ? f_offset(w_v_next) : 9'd0;
        w_upt     = w_cycle ? w_m_next : 1'b0;
        w_clr_sel = w_clr_req ? w_v_next : 2'b00;
    end

endmodule

// File: doc/trap_ctl.md
TRAP_CTL -- requirements
Module: trap_ctl

Interface
REQ-001 The block SHALL have these ports (clock and reset first): eboxClk  in  1  EBOX clock, all state updates on rising edge.
REQ-002 eboxReset  in  1  reset, synchronous and active-high.
REQ-003 SCD_TRAP_REQ1  in  1  arithmetic-overflow trap request flag from the shift-count/flags board.
REQ-004 SCD_TRAP_REQ2  in  1  pushdown-overflow trap request flag from the shift-count/flags board.
REQ-005 SCD_USER  in  1  processor in user mode.
REQ-006 CON_TRAP_EN  in  1  trapping enabled; when low, requests are ignored in IDLE.
REQ-007 CON_INST_DONE  in  1  one-cycle pulse at the instruction boundary.
REQ-008 PI_REQ  in  1  priority interrupt pending; outranks traps.
REQ-009 PF_ABORT  in  1  page-fail abort of the current trap cycle.
REQ-010 CON_TRAP_TAKEN  in  1  microcode acknowledge of the trap dispatch.
REQ-011 TRAP_PEND  out  1  requests latched, awaiting boundary.
REQ-012 TRAP_CYCLE  out  1  trap dispatch active.
REQ-013 TRAP_OFFSET  out  [0:8]  process-table offset of the trap instruction.
REQ-014 TRAP_UPT  out  1  1 = user process table, 0 = exec process table.
REQ-015 TRAP_CLR_REQ  out  1  one-cycle pulse clearing the served request flags.
REQ-016 TRAP_CLR_SEL  out  [1:2]  which flags to clear: bit1 = REQ1, bit2 = REQ2.
REQ-017 TRAP_HANG  out  1  sticky watchdog error flag.

Function
REQ-018 The state machine SHALL have 4 states: IDLE, ARM, DISPATCH, CLEAR.
REQ-019 IDLE: if CON_TRAP_EN and (REQ1|REQ2) -> ARM next cycle; latch the request vector V={REQ1,REQ2} and the mode M=SCD_USER.
REQ-020 ARM: V SHALL OR in newly asserted requests each cycle; M SHALL track SCD_USER; TRAP_PEND=1.
REQ-021 ARM with CON_INST_DONE=1 and PI_REQ=0 -> DISPATCH; V and M freeze.
REQ-022 ARM with CON_INST_DONE=1 and PI_REQ=1 -> stay in ARM; V is retained (the interrupt wins the boundary).
REQ-023 DISPATCH: TRAP_CYCLE=1; TRAP_OFFSET = 0o421 (V=10), 0o422 (V=01), 0o423 (V=11); TRAP_UPT=M.
REQ-024 TRAP_OFFSET and TRAP_UPT SHALL be registered and held stable for the whole of DISPATCH; they are 0 outside DISPATCH.
REQ-025 DISPATCH with CON_TRAP_TAKEN=1 -> CLEAR.
REQ-026 DISPATCH with PF_ABORT=1 -> ARM with V retained; PF_ABORT outranks CON_TRAP_TAKEN in the same cycle.
REQ-027 CLEAR: TRAP_CLR_REQ=1 for exactly one cycle with TRAP_CLR_SEL=V, then -> IDLE with V cleared.
REQ-028 Requests arriving during DISPATCH or CLEAR SHALL NOT alter V; they are picked up from IDLE once the flags are still set.
REQ-029 CON_TRAP_EN dropping SHALL NOT abort ARM or DISPATCH; it gates only the IDLE->ARM entry.
REQ-030 Watchdog: an 8-bit counter SHALL clear on DISPATCH entry and increment each DISPATCH cycle; on reaching 255, TRAP_HANG sets and stays set until reset; the FSM stays in DISPATCH.
REQ-031 All outputs SHALL be registered; latency from the CON_INST_DONE edge to TRAP_CYCLE=1 is 1 cycle.

Reset
REQ-032 eboxReset=1 at a clock edge SHALL force IDLE, V=0, M=0, watchdog=0, and drive all outputs to 0 (including TRAP_HANG), from any state.
REQ-033 Reset mid-DISPATCH SHALL NOT produce a TRAP_CLR_REQ pulse.

Verification
REQ-034 REQ1=1, EN=1, SCD_USER=1, INST_DONE pulse, PI_REQ=0 -> TRAP_CYCLE=1 next cycle, OFFSET=0o421, UPT=1; TAKEN -> one-cycle CLR_REQ with SEL=10 -> IDLE.
REQ-035 REQ2 latched, REQ1 rises while in ARM -> at dispatch OFFSET=0o423, SEL=11.
REQ-036 ARM, INST_DONE with PI_REQ=1 -> stays ARM, TRAP_PEND=1; next INST_DONE with PI_REQ=0 -> DISPATCH.
REQ-037 DISPATCH, PF_ABORT and TAKEN in the same cycle -> ARM, no CLR_REQ; V unchanged.
REQ-038 DISPATCH held 255 cycles without TAKEN -> TRAP_HANG=1; eboxReset -> all outputs 0, IDLE.
REQ-039 EN=0 with REQ1=1 in IDLE -> no state change, all outputs 0.
